// File: rtl/acorn128_out_stage.sv
// acorn128_out_stage: captures the ACORN-128 core result and streams it as OUT_W-bit beats.
// Optional tag authentication in decrypt mode is enabled by ACORN128_TAG_CHECK_EN.
module acorn128_out_stage #(
    parameter int OUT_W = 8,
    parameter int CMP_W = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               core_ready_in,
    input  logic               core_encrypt_in,
    input  logic [127:0]       core_data_in,
    input  logic [127:0]       core_tag_in,
    input  logic [127:0]       expected_tag_in,
    output logic [OUT_W-1:0]   m_data_out,
    output logic               m_valid_out,
    input  logic               m_ready_in,
    output logic               m_last_out,
    output logic               busy_out,
    output logic               done_out,
    output logic               auth_fail_out,
    output logic               overrun_out
);

    localparam int NB_ALL  = 256 / OUT_W;
    localparam int NB_DATA = 128 / OUT_W;
    localparam int BW      = $clog2(NB_ALL + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CMP,
        S_STREAM,
        S_DONE
    } state_t;

    state_t             r_state;
    state_t             w_nstate;
    logic               r_ready_d;
    logic [127:0]       r_data;
    logic [127:0]       r_tag;
    logic [BW-1:0]      r_beat_cnt;
    logic [OUT_W-1:0]   r_dout;
    logic               r_valid;
    logic               r_last;
    logic               r_busy;
    logic               r_done;
    logic               r_overrun;

    logic               w_capture;
    logic               w_hs;
    logic [BW-1:0]      w_nidx;
    logic [BW-1:0]      w_last_idx;
    logic [255:0]       w_st_sh;
    logic [OUT_W-1:0]   w_next_beat;

`ifdef ACORN128_TAG_CHECK_EN
    localparam int NCMP = 128 / CMP_W;
    localparam int CW   = $clog2(NCMP + 1);

    logic [127:0]       r_exp;
    logic               r_enc;
    logic [CMP_W-1:0]   r_diff;
    logic [CW-1:0]      r_cmp_cnt;
    logic               r_auth_fail;
    logic [127:0]       w_tag_sh;
    logic [127:0]       w_exp_sh;
    logic [CMP_W-1:0]   w_diff_nx;
    logic               w_cmp_last;

    // Fixed-length compare: every slice is visited regardless of the data.
    assign w_tag_sh   = r_tag << (32'(r_cmp_cnt) * CMP_W);
    assign w_exp_sh   = r_exp << (32'(r_cmp_cnt) * CMP_W);
    assign w_diff_nx  = r_diff | (w_tag_sh[127 -: CMP_W] ^ w_exp_sh[127 -: CMP_W]);
    assign w_cmp_last = (r_cmp_cnt == CW'(NCMP - 1));
    assign w_last_idx = r_enc ? BW'(NB_ALL - 1) : BW'(NB_DATA - 1);
    assign auth_fail_out = r_auth_fail;
`else
    logic               w_unused_exp;

    assign w_unused_exp  = ^expected_tag_in;
    assign w_last_idx    = BW'(NB_ALL - 1);
    assign auth_fail_out = 1'b0;
`endif

    assign w_capture   = core_ready_in & ~r_ready_d;
    assign w_hs        = r_valid & m_ready_in;
    assign w_nidx      = r_beat_cnt + 1'b1;
    assign w_st_sh     = {r_data, r_tag} << (32'(w_nidx) * OUT_W);
    assign w_next_beat = w_st_sh[255 -: OUT_W];

    assign m_data_out  = r_dout;
    assign m_valid_out = r_valid;
    assign m_last_out  = r_last;
    assign busy_out    = r_busy;
    assign done_out    = r_done;
    assign overrun_out = r_overrun;

    always_comb begin
        w_nstate = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (w_capture) begin
`ifdef ACORN128_TAG_CHECK_EN
                    w_nstate = core_encrypt_in ? S_STREAM : S_CMP;
`else
                    w_nstate = S_STREAM;
`endif
                end
            end
`ifdef ACORN128_TAG_CHECK_EN
            S_CMP: begin
                if (w_cmp_last)
                    w_nstate = (w_diff_nx == '0) ? S_STREAM : S_DONE;
            end
`else
            S_CMP: w_nstate = S_IDLE;
`endif
            S_STREAM: begin
                if (w_hs && r_last)
                    w_nstate = S_DONE;
            end
            S_DONE: w_nstate = S_IDLE;
            default: w_nstate = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_nstate;
            r_busy  <= (w_nstate != S_IDLE);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ready_d   <= 1'b0;
            r_data      <= '0;
            r_tag       <= '0;
            r_beat_cnt  <= '0;
            r_dout      <= '0;
            r_valid     <= 1'b0;
            r_last      <= 1'b0;
            r_done      <= 1'b0;
            r_overrun   <= 1'b0;
`ifdef ACORN128_TAG_CHECK_EN
            r_exp       <= '0;
            r_enc       <= 1'b0;
            r_diff      <= '0;
            r_cmp_cnt   <= '0;
            r_auth_fail <= 1'b0;
`endif
        end else begin
            r_ready_d <= core_ready_in;
            r_done    <= 1'b0;
            // A new result while busy is dropped and only flagged.
            if (w_capture && r_state != S_IDLE)
                r_overrun <= 1'b1;
            case (r_state)
                S_IDLE: begin
                    if (w_capture) begin
                        r_data <= core_data_in;
                        r_tag  <= core_tag_in;
`ifdef ACORN128_TAG_CHECK_EN
                        r_exp       <= expected_tag_in;
                        r_enc       <= core_encrypt_in;
                        r_auth_fail <= 1'b0;
                        r_diff      <= '0;
                        r_cmp_cnt   <= '0;
                        if (core_encrypt_in) begin
                            r_valid    <= 1'b1;
                            r_dout     <= core_data_in[127 -: OUT_W];
                            r_last     <= 1'b0;
                            r_beat_cnt <= '0;
                        end
`else
                        r_valid    <= 1'b1;
                        r_dout     <= core_data_in[127 -: OUT_W];
                        r_last     <= 1'b0;
                        r_beat_cnt <= '0;
`endif
                    end
                end
`ifdef ACORN128_TAG_CHECK_EN
                S_CMP: begin
                    r_diff    <= w_diff_nx;
                    r_cmp_cnt <= r_cmp_cnt + 1'b1;
                    if (w_cmp_last) begin
                        if (w_diff_nx == '0) begin
                            r_valid    <= 1'b1;
                            r_dout     <= r_data[127 -: OUT_W];
                            r_last     <= (NB_DATA == 1);
                            r_beat_cnt <= '0;
                        end else begin
                            // Unauthenticated plaintext must never leave the block.
                            r_auth_fail <= 1'b1;
                            r_data      <= '0;
                            r_tag       <= '0;
                            r_done      <= 1'b1;
                        end
                    end
                end
`endif
                S_STREAM: begin
                    if (w_hs) begin
                        if (r_last) begin
                            r_valid <= 1'b0;
                            r_last  <= 1'b0;
                            r_dout  <= '0;
                            r_done  <= 1'b1;
                        end else begin
                            r_beat_cnt <= w_nidx;
                            r_dout     <= w_next_beat;
                            r_last     <= (w_nidx == w_last_idx);
                        end
                    end
                end
                S_DONE: begin
                    r_data     <= '0;
                    r_tag      <= '0;
                    r_beat_cnt <= '0;
`ifdef ACORN128_TAG_CHECK_EN
                    r_exp     <= '0;
                    r_enc     <= 1'b0;
                    r_diff    <= '0;
                    r_cmp_cnt <= '0;
`endif
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/acorn128_out_stage.md
# acorn128_out_stage

Output stage directly downstream of `acorn128_top`. It captures the 128-bit data word and 128-bit tag when the core raises `ready_out`. In decrypt mode it checks the computed tag against the expected tag. It then streams the result as OUT_W-bit beats over a valid/ready interface, and withholds plaintext whose tag fails to authenticate.

## Interface
- `OUT_W`, default 8, output beat width; must divide 128 (legal values: 8, 16, 32, 64, 128).
- `CMP_W`, default 32, tag bits compared per cycle; must divide 128.
- `clk` in 1: system clock; all logic on the rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `core_ready_in` in 1: connects to core `ready_out`; level signal.
- `core_encrypt_in` in 1: mode applied to the result being captured; 1 = encrypt, 0 = decrypt.
- `core_data_in` in 128: core `ciphertext_out`; carries plaintext in decrypt mode.
- `core_tag_in` in 128: core `tag_out`.
- `expected_tag_in` in 128: received tag; sampled at capture and used only in decrypt mode.
- `m_data_out` out OUT_W: stream data; MSB-first slices.
- `m_valid_out` out 1: stream valid.
- `m_ready_in` in 1: stream ready from the sink.
- `m_last_out` out 1: high on the final beat of a result.
- `busy_out` out 1: high in any state other than IDLE.
- `done_out` out 1: one-cycle pulse when a result completes.
- `auth_fail_out` out 1: tag mismatch; held until the next capture.
- `overrun_out` out 1: sticky flag; cleared only by reset.

## Operation
- Four states: IDLE, CMP, STREAM, DONE.
- **IDLE**
  - Capture occurs when `core_ready_in` is 1 now and was 0 in the previous registered sample (rising-edge detect).
  - On capture, register data, tag, expected tag and mode, and clear `auth_fail_out`.
  - Encrypt mode goes to STREAM. Decrypt mode goes to CMP.
- **CMP**
  - Runs 128/CMP_W cycles.
  - Each cycle XORs one CMP_W slice of the captured tag against the matching slice of the expected tag, MSB slice first, and ORs the result into a diff accumulator.
  - There is no early exit; the cycle count is independent of the data.
  - On the last slice: if diff is zero, go to STREAM. Otherwise set `auth_fail_out`, zero the data and tag registers, and go to DONE.
- **STREAM**
  - Beat counter runs from 0.
  - Encrypt mode: 256/OUT_W beats, data[127:0] MSB-first, then tag[127:0] MSB-first.
  - Decrypt mode: 128/OUT_W beats of data only.
  - The counter advances only on `m_valid_out && m_ready_in`.
  - `m_last_out` is high on the final beat only.
  - Acceptance of the final beat goes to DONE.
- **DONE**
  - Pulses `done_out` for one cycle, then returns to IDLE.
  - Captured registers are cleared on this transition.
- **Overrun:** a capture edge in any state other than IDLE sets `overrun_out`. That result is dropped and the current operation is unaffected.
- **Simultaneous events:** a capture edge in the same cycle as the DONE→IDLE transition counts as an overrun. Capture is accepted only while the state is IDLE.

## Timing
- **Reset values:** every output and every internal register is 0, and the FSM is in IDLE. Reset asserted mid-operation aborts immediately with no `done_out`. The edge detector resets to 0, so a `core_ready_in` already high at reset release captures on the first clock.
- **Capture:** cycle N is the edge where `core_ready_in` is detected.
  - Encrypt: `m_valid_out` is first high in cycle N+1.
  - Decrypt: CMP occupies cycles N+1 .. N+128/CMP_W, and `m_valid_out` is first high in the following cycle.
- **Throughput:** with `m_ready_in` held high, one beat per cycle.
- **Valid/ready rules:**
  - `m_data_out` and `m_last_out` are stable while `m_valid_out && !m_ready_in`.
  - `m_valid_out` never drops before acceptance.
  - `m_valid_out` does not depend combinationally on `m_ready_in`.
- **Completion:** `done_out` is high the cycle after the final beat handshake. On an auth failure it is high the cycle after the last CMP cycle, with no beats emitted.
- **Outputs:** all outputs are registered.

## Configuration
- Macro: `ACORN128_TAG_CHECK_EN`.
- **Defined:** decrypt behaviour exactly as described in Operation.
- **Undefined:**
  - CMP state is not built.
  - Decrypt captures go straight to STREAM and emit data then tag, 256/OUT_W beats, the same as encrypt mode.
  - `auth_fail_out` is tied to 0.
  - `expected_tag_in` is ignored.

## Test plan
- **Encrypt, backpressure-free** (OUT_W=8, CMP_W=32): capture data AABBCCDDEEFF00112233445566778899 and a tag. Require 32 beats: AA, BB, … 99, then the tag bytes MSB-first. `m_last_out` only on beat 32; `done_out` one cycle later.
- **Backpressure:** toggle `m_ready_in` 1,0,0,1 repeatedly. Data is held stable while stalled and no beat is duplicated or lost. Exactly 32 handshakes occur and the byte order matches the no-backpressure case.
- **Decrypt, tag match:** core tag = expected tag = 0123456789ABCDEF0123456789ABCDEF. Four CMP cycles, then 16 plaintext beats; `auth_fail_out` stays 0.
- **Decrypt, tag mismatch:** flip bit 0 of the expected tag. Still four CMP cycles; no `m_valid_out`; `auth_fail_out`=1 and `done_out` pulses. The next capture clears `auth_fail_out`.
- **Overrun:** pulse `core_ready_in` low→high during STREAM. `overrun_out`=1 and the stream completes unchanged.
- **Mid-stream reset:** drive `rst` low at beat 5. All outputs are 0 asynchronously. After release, a new capture streams correctly from beat 0.
- **Macro undefined:** a decrypt capture emits 32 beats (data then tag) with no CMP cycles, and `auth_fail_out` stays 0.
